handshake_rr_arbiter: RTL



---
 rtl/handshake_rr_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one downstream request/response channel between
// NREQ requesters. One grant at a time; the grant is held until the downstream
// response returns or a timeout expires, then the response is routed back.
module handshake_rr_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      rsp_err,
    output logic                      down_valid,
    output logic [WIDTH-1:0]          down_data,
    input  logic                      down_ready,
    input  logic                      down_rsp_valid,
    input  logic [WIDTH-1:0]          down_rsp_data,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned CNTW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     ptr, ptr_nxt;
    logic [IDW-1:0]     grant_nxt;
    logic [IDW-1:0]     grant_inc;
    logic [WIDTH-1:0]   down_data_nxt;
    logic               down_valid_nxt;
    logic               busy_nxt;
    logic [CNTW-1:0]    cnt, cnt_nxt;
    logic [NREQ-1:0]    rsp_valid_nxt;
    logic [WIDTH-1:0]   rsp_data_nxt;
    logic               rsp_err_nxt;

    logic               pick_found;
    logic [IDW-1:0]     pick_idx;
    int unsigned        scan_pos;
    logic [WIDTH-1:0]   req_word [NREQ];

    // Unpack the flat request bus into per-requester words
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Find the first pending requester at or above ptr, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_pos   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_pos = 32'(ptr) + i;
            if (scan_pos >= NREQ) begin
                scan_pos = scan_pos - NREQ;
            end
            if (!pick_found && req_valid[IDW'(scan_pos)]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'(scan_pos);
            end
        end
    end

    // Index following the current grant, used to rotate priority on exit
    always_comb begin
        if (grant_id == IDW'(NREQ - 1)) begin
            grant_inc = '0;
        end else begin
            grant_inc = grant_id + IDW'(1);
        end
    end

    // Accept pulse follows the downstream handshake within the same cycle
    always_comb begin
        req_ready = '0;
        if (state == SEND && down_ready) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        grant_nxt     = grant_id;
        down_data_nxt = down_data;
        cnt_nxt       = cnt;
        rsp_valid_nxt = '0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt     = pick_idx;
                    down_data_nxt = req_word[pick_idx];
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                if (down_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A real response beats a timeout landing in the same cycle
                if (down_rsp_valid) begin
                    rsp_valid_nxt[grant_id] = 1'b1;
                    rsp_data_nxt            = down_rsp_data;
                    rsp_err_nxt             = 1'b0;
                    ptr_nxt                 = grant_inc;
                    state_nxt               = IDLE;
                end else if (cnt == CNTW'(TIMEOUT)) begin
                    rsp_valid_nxt[grant_id] = 1'b1;
                    rsp_data_nxt            = '1;
                    rsp_err_nxt             = 1'b1;
                    ptr_nxt                 = grant_inc;
                    state_nxt               = IDLE;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        down_valid_nxt = (state_nxt == SEND);
        busy_nxt       = (state_nxt != IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            grant_id   <= '0;
            down_data  <= '0;
            down_valid <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            ptr        <= ptr_nxt;
            grant_id   <= grant_nxt;
            down_data  <= down_data_nxt;
            down_valid <= down_valid_nxt;
            busy       <= busy_nxt;
            cnt        <= cnt_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_data   <= rsp_data_nxt;
            rsp_err    <= rsp_err_nxt;
        end
    end

endmodule
